// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard interface: decoded instruction fields toward the hazard
// controller and pipeline control (stall/flush/issue/bypass/halt) back out.
interface hazard_ctrl_if #(
    parameter int AW   = 4,
    parameter int NBYP = 2
);
    logic            id_valid;
    logic            rf_re0;
    logic            rf_re1;
    logic [AW-1:0]   rf_p0_addr;
    logic [AW-1:0]   rf_p1_addr;
    logic            rf_we;
    logic [AW-1:0]   rf_dst_addr;
    logic            dm_re;
    logic            hlt;
    logic            lwi;
    logic            flow_change;
    logic            stall_if;
    logic            flush;
    logic            issue;
    logic [NBYP-1:0] byp0;
    logic [NBYP-1:0] byp1;
    logic            hlt_wb;
    logic            lwi_busy;

    modport master (
        output id_valid, rf_re0, rf_re1, rf_p0_addr, rf_p1_addr,
               rf_we, rf_dst_addr, dm_re, hlt, lwi, flow_change,
        input  stall_if, flush, issue, byp0, byp1, hlt_wb, lwi_busy
    );

    modport slave (
        input  id_valid, rf_re0, rf_re1, rf_p0_addr, rf_p1_addr,
               rf_we, rf_dst_addr, dm_re, hlt, lwi, flow_change,
        output stall_if, flush, issue, byp0, byp1, hlt_wb, lwi_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: writer-tag bypass selection, load-use stall,
// wrong-path flush, sticky halt with WB notification and LWI/MOVC sequencing.
module hazard_ctrl #(
    parameter int NREG        = 16,
    parameter int NBYP        = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int LWI_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    localparam int AW = $clog2(NREG);
    localparam int CW = 3;
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_DEPTH - 1);
    localparam logic [CW-1:0] LWI_LOAD   = CW'((LWI_CYCLES > 1) ? (LWI_CYCLES - 2) : 0);

    typedef enum logic [0:0] {
        LWI_IDLE = 1'b0,
        LWI_BUSY = 1'b1
    } lwi_state_e;

    logic [NBYP-1:0] tag_we_q, tag_we_d;
    logic [NBYP-1:0] tag_ld_q, tag_ld_d;
    logic [AW-1:0]   tag_dst_q [NBYP];
    logic [AW-1:0]   tag_dst_d [NBYP];
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            halted_q, halted_d;
    logic [NBYP:0]   hlt_pipe_q, hlt_pipe_d;
    lwi_state_e      lwi_state_q, lwi_state_d;
    logic [CW-1:0]   lwi_cnt_q, lwi_cnt_d;

    logic            flush_s;
    logic            load_use_s;
    logic            lwi_hold_s;
    logic            issue_s;
    logic            hit0_s;
    logic            hit1_s;
    logic [NBYP-1:0] byp0_s;
    logic [NBYP-1:0] byp1_s;

    // Hazard detection and the issue decision for the instruction held in ID.
    always_comb begin
        flush_s    = hz.flow_change | (flush_cnt_q != CNT_ZERO);
        lwi_hold_s = (lwi_state_q == LWI_BUSY);
        load_use_s = tag_ld_q[0] & tag_we_q[0] &
                     ((hz.rf_re0 & (tag_dst_q[0] == hz.rf_p0_addr)) |
                      (hz.rf_re1 & (tag_dst_q[0] == hz.rf_p1_addr)));
        issue_s    = hz.id_valid & ~flush_s & ~halted_q & ~load_use_s &
                     ~(lwi_hold_s & (lwi_cnt_q != CNT_ZERO));
    end

    // Bypass select: the youngest matching writer wins, register 0 never forwards.
    always_comb begin
        byp0_s = {NBYP{1'b0}};
        byp1_s = {NBYP{1'b0}};
        hit0_s = 1'b0;
        hit1_s = 1'b0;
        for (int k = 0; k < NBYP; k++) begin
            if (!hit0_s && hz.rf_re0 && tag_we_q[k] &&
                (tag_dst_q[k] == hz.rf_p0_addr) && (hz.rf_p0_addr != {AW{1'b0}})) begin
                byp0_s[k] = 1'b1;
                hit0_s    = 1'b1;
            end else begin
                byp0_s[k] = 1'b0;
            end
            if (!hit1_s && hz.rf_re1 && tag_we_q[k] &&
                (tag_dst_q[k] == hz.rf_p1_addr) && (hz.rf_p1_addr != {AW{1'b0}})) begin
                byp1_s[k] = 1'b1;
                hit1_s    = 1'b1;
            end else begin
                byp1_s[k] = 1'b0;
            end
        end
    end

    // Tag pipeline shift, flush countdown, sticky halt and halt-to-WB delay line.
    always_comb begin
        tag_we_d  = tag_we_q;
        tag_ld_d  = tag_ld_q;
        tag_dst_d = tag_dst_q;
        for (int k = 1; k < NBYP; k++) begin
            tag_we_d[k]  = tag_we_q[k-1];
            tag_ld_d[k]  = tag_ld_q[k-1];
            tag_dst_d[k] = tag_dst_q[k-1];
        end
        if (issue_s) begin
            tag_we_d[0]  = hz.rf_we & (hz.rf_dst_addr != {AW{1'b0}});
            tag_ld_d[0]  = hz.dm_re;
            tag_dst_d[0] = hz.rf_dst_addr;
        end else begin
            tag_we_d[0]  = 1'b0;
            tag_ld_d[0]  = 1'b0;
            tag_dst_d[0] = {AW{1'b0}};
        end

        if (hz.flow_change) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != CNT_ZERO) begin
            flush_cnt_d = flush_cnt_q - CNT_ONE;
        end else begin
            flush_cnt_d = CNT_ZERO;
        end

        halted_d = halted_q | (hz.hlt & hz.id_valid & ~flush_s);

        hlt_pipe_d    = hlt_pipe_q;
        hlt_pipe_d[0] = issue_s & hz.hlt;
        for (int k = 1; k <= NBYP; k++) begin
            hlt_pipe_d[k] = hlt_pipe_q[k-1];
        end
        // Last tap is sticky so the halt notification holds until reset.
        hlt_pipe_d[NBYP] = hlt_pipe_q[NBYP-1] | hlt_pipe_q[NBYP];
    end

    // LWI/MOVC sequencer next state; a flush only ends the hold, the LWI already issued.
    always_comb begin
        lwi_state_d = lwi_state_q;
        lwi_cnt_d   = lwi_cnt_q;
        case (lwi_state_q)
            LWI_IDLE: begin
                if (issue_s && hz.lwi && (LWI_CYCLES > 1)) begin
                    lwi_state_d = LWI_BUSY;
                    lwi_cnt_d   = LWI_LOAD;
                end else begin
                    lwi_state_d = LWI_IDLE;
                    lwi_cnt_d   = CNT_ZERO;
                end
            end
            LWI_BUSY: begin
                if (flush_s || (lwi_cnt_q == CNT_ZERO)) begin
                    lwi_state_d = LWI_IDLE;
                    lwi_cnt_d   = CNT_ZERO;
                end else begin
                    lwi_state_d = LWI_BUSY;
                    lwi_cnt_d   = lwi_cnt_q - CNT_ONE;
                end
            end
            default: begin
                lwi_state_d = LWI_IDLE;
                lwi_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_we_q    <= {NBYP{1'b0}};
            tag_ld_q    <= {NBYP{1'b0}};
            for (int k = 0; k < NBYP; k++) begin
                tag_dst_q[k] <= {AW{1'b0}};
            end
            flush_cnt_q <= CNT_ZERO;
            halted_q    <= 1'b0;
            hlt_pipe_q  <= {(NBYP+1){1'b0}};
            lwi_state_q <= LWI_IDLE;
            lwi_cnt_q   <= CNT_ZERO;
        end else begin
            tag_we_q    <= tag_we_d;
            tag_ld_q    <= tag_ld_d;
            tag_dst_q   <= tag_dst_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= halted_d;
            hlt_pipe_q  <= hlt_pipe_d;
            lwi_state_q <= lwi_state_d;
            lwi_cnt_q   <= lwi_cnt_d;
        end
    end

    assign hz.flush    = flush_s;
    assign hz.issue    = issue_s;
    assign hz.stall_if = (halted_q | load_use_s | lwi_hold_s) & ~flush_s;
    assign hz.byp0     = byp0_s;
    assign hz.byp1     = byp1_s;
    assign hz.hlt_wb   = hlt_pipe_q[NBYP];
    assign hz.lwi_busy = lwi_hold_s;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios against fixed
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int NREG        = 16;
    localparam int AW          = 4;
    localparam int NBYP        = 2;
    localparam int FLUSH_DEPTH = 2;
    localparam int LWI_CYCLES  = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hazard_ctrl_if #(.AW(AW), .NBYP(NBYP)) hz ();

    hazard_ctrl #(
        .NREG(NREG), .NBYP(NBYP), .FLUSH_DEPTH(FLUSH_DEPTH), .LWI_CYCLES(LWI_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    always #5 clk = ~clk;

    // Model: in-flight writers, remaining flush cycles, halt age, remaining LWI busy cycles.
    bit              m_we  [NBYP];
    int              m_dst [NBYP];
    bit              m_ld  [NBYP];
    int              m_flush_left;
    int              m_hlt_age;
    int              m_lwi_left;
    bit              m_halted;
    bit              e_flush, e_issue, e_stall, e_busy, e_hlt_wb, e_lu;
    logic [NBYP-1:0] e_byp0, e_byp1;

    task automatic model_reset();
        for (int k = 0; k < NBYP; k++) begin
            m_we[k] = 1'b0; m_dst[k] = 0; m_ld[k] = 1'b0;
        end
        m_flush_left = 0; m_hlt_age = 0; m_lwi_left = 0; m_halted = 1'b0;
    endtask

    task automatic model_eval();
        e_flush  = hz.flow_change || (m_flush_left > 0);
        e_busy   = (m_lwi_left > 0);
        e_lu     = m_ld[0] && m_we[0] &&
                   ((hz.rf_re0 && m_dst[0] == int'(hz.rf_p0_addr)) ||
                    (hz.rf_re1 && m_dst[0] == int'(hz.rf_p1_addr)));
        e_issue  = hz.id_valid && !e_flush && !m_halted && !e_lu && !(m_lwi_left > 1);
        e_stall  = (m_halted || e_lu || e_busy) && !e_flush;
        e_hlt_wb = (m_hlt_age >= NBYP + 1);
        e_byp0   = {NBYP{1'b0}};
        e_byp1   = {NBYP{1'b0}};
        for (int k = NBYP - 1; k >= 0; k--) begin
            if (hz.rf_re0 && m_we[k] && m_dst[k] == int'(hz.rf_p0_addr) && hz.rf_p0_addr != 4'd0) begin
                e_byp0 = {NBYP{1'b0}}; e_byp0[k] = 1'b1;
            end
            if (hz.rf_re1 && m_we[k] && m_dst[k] == int'(hz.rf_p1_addr) && hz.rf_p1_addr != 4'd0) begin
                e_byp1 = {NBYP{1'b0}}; e_byp1[k] = 1'b1;
            end
        end
    endtask

    // Advance the model by one clock using the inputs currently applied, then step the clock.
    task automatic tick();
        model_eval();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = NBYP - 1; k > 0; k--) begin
                m_we[k] = m_we[k-1]; m_dst[k] = m_dst[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_we[0]  = e_issue && hz.rf_we && (hz.rf_dst_addr != 4'd0);
            m_dst[0] = e_issue ? int'(hz.rf_dst_addr) : 0;
            m_ld[0]  = e_issue && hz.dm_re;
            if (hz.id_valid && hz.hlt && !e_flush) m_halted = 1'b1;
            if (e_issue && hz.hlt) m_hlt_age = 1;
            else if (m_hlt_age > 0 && m_hlt_age < NBYP + 1) m_hlt_age++;
            if (m_lwi_left > 0) m_lwi_left = e_flush ? 0 : m_lwi_left - 1;
            else if (e_issue && hz.lwi && LWI_CYCLES > 1) m_lwi_left = LWI_CYCLES - 1;
            m_flush_left = hz.flow_change ? FLUSH_DEPTH - 1 : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic idle();
        hz.id_valid = 1'b0; hz.rf_re0 = 1'b0; hz.rf_re1 = 1'b0;
        hz.rf_p0_addr = 4'd0; hz.rf_p1_addr = 4'd0; hz.rf_we = 1'b0;
        hz.rf_dst_addr = 4'd0; hz.dm_re = 1'b0; hz.hlt = 1'b0; hz.lwi = 1'b0;
        hz.flow_change = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < NBYP + 3; i++) tick();
    endtask

    task automatic test_reset();
        idle(); hz.id_valid = 1'b1; hz.rf_re0 = 1'b1; hz.rf_p0_addr = 4'd3;
        sample();
        checks++; if (hz.stall_if !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", hz.stall_if); end
        checks++; if (hz.flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", hz.flush); end
        checks++; if (hz.byp0 !== 2'b00) begin failures++; $display("FAIL reset_byp0 got=%b exp=00", hz.byp0); end
        checks++; if (hz.byp1 !== 2'b00) begin failures++; $display("FAIL reset_byp1 got=%b exp=00", hz.byp1); end
        checks++; if (hz.hlt_wb !== 1'b0) begin failures++; $display("FAIL reset_hlt_wb got=%0b exp=0", hz.hlt_wb); end
        checks++; if (hz.lwi_busy !== 1'b0) begin failures++; $display("FAIL reset_lwi_busy got=%0b exp=0", hz.lwi_busy); end
        checks++; if (hz.issue !== 1'b1) begin failures++; $display("FAIL reset_issue got=%0b exp=1", hz.issue); end
        tick(); drain();
    endtask

    task automatic test_bypass();
        idle(); hz.id_valid = 1'b1; hz.rf_we = 1'b1; hz.rf_dst_addr = 4'd3;
        sample();
        checks++; if (hz.issue !== 1'b1) begin failures++; $display("FAIL byp_add_issue got=%0b exp=1", hz.issue); end
        tick();
        idle(); hz.id_valid = 1'b1; hz.rf_re0 = 1'b1; hz.rf_p0_addr = 4'd3;
        sample();
        checks++; if (hz.byp0 !== 2'b01) begin failures++; $display("FAIL byp_p0_ex got=%b exp=01", hz.byp0); end
        tick();
        idle(); hz.id_valid = 1'b1; hz.rf_re1 = 1'b1; hz.rf_p1_addr = 4'd3;
        sample();
        checks++; if (hz.byp1 !== 2'b10) begin failures++; $display("FAIL byp_p1_dm got=%b exp=10", hz.byp1); end
        tick();
        // A load to R0 must leave no tracked writer: no bypass, no load-use stall.
        idle(); hz.id_valid = 1'b1; hz.rf_we = 1'b1; hz.rf_dst_addr = 4'd0; hz.dm_re = 1'b1;
        tick();
        idle(); hz.id_valid = 1'b1; hz.rf_re0 = 1'b1; hz.rf_re1 = 1'b1;
        sample();
        checks++; if (hz.byp0 !== 2'b00 || hz.byp1 !== 2'b00) begin failures++; $display("FAIL byp_r0 got=%b/%b exp=00/00", hz.byp0, hz.byp1); end
        checks++; if (hz.stall_if !== 1'b0 || hz.issue !== 1'b1) begin failures++; $display("FAIL r0_no_loaduse stall=%0b issue=%0b exp 0/1", hz.stall_if, hz.issue); end
        tick(); drain();
    endtask

    task automatic test_load_use();
        idle(); hz.id_valid = 1'b1; hz.rf_we = 1'b1; hz.rf_dst_addr = 4'd5; hz.dm_re = 1'b1;
        tick();
        idle(); hz.id_valid = 1'b1; hz.rf_re0 = 1'b1; hz.rf_p0_addr = 4'd5; hz.rf_we = 1'b1; hz.rf_dst_addr = 4'd6;
        sample();
        checks++; if (hz.stall_if !== 1'b1 || hz.issue !== 1'b0) begin failures++; $display("FAIL lu_stall stall=%0b issue=%0b exp 1/0", hz.stall_if, hz.issue); end
        tick();
        sample();
        checks++; if (hz.stall_if !== 1'b0 || hz.issue !== 1'b1) begin failures++; $display("FAIL lu_release stall=%0b issue=%0b exp 0/1", hz.stall_if, hz.issue); end
        checks++; if (hz.byp0 !== 2'b10) begin failures++; $display("FAIL lu_byp0 got=%b exp=10", hz.byp0); end
        tick(); drain();
    endtask

    task automatic test_flush();
        int n;
        idle(); hz.id_valid = 1'b1; hz.flow_change = 1'b1;
        sample();
        checks++; if (hz.flush !== 1'b1 || hz.issue !== 1'b0) begin failures++; $display("FAIL flush_c0 flush=%0b issue=%0b exp 1/0", hz.flush, hz.issue); end
        tick();
        hz.flow_change = 1'b0;
        sample();
        checks++; if (hz.flush !== 1'b1 || hz.issue !== 1'b0) begin failures++; $display("FAIL flush_c1 flush=%0b issue=%0b exp 1/0", hz.flush, hz.issue); end
        tick();
        sample();
        checks++; if (hz.flush !== 1'b0 || hz.issue !== 1'b1) begin failures++; $display("FAIL flush_end flush=%0b issue=%0b exp 0/1", hz.flush, hz.issue); end
        tick();
        idle();
        n = 0;
        for (int c = 0; c < 6; c++) begin
            hz.flow_change = (c < 2);
            sample();
            if (hz.flush === 1'b1) n++;
            tick();
        end
        checks++; if (n != 3) begin failures++; $display("FAIL flush_reload cycles=%0d exp=3", n); end
        drain();
    endtask

    task automatic test_lwi();
        idle(); hz.id_valid = 1'b1; hz.lwi = 1'b1; hz.rf_we = 1'b1; hz.rf_dst_addr = 4'd7;
        sample();
        checks++; if (hz.issue !== 1'b1 || hz.lwi_busy !== 1'b0) begin failures++; $display("FAIL lwi_issue issue=%0b busy=%0b exp 1/0", hz.issue, hz.lwi_busy); end
        tick();
        idle(); hz.id_valid = 1'b1;
        sample();
        checks++; if (hz.lwi_busy !== 1'b1 || hz.stall_if !== 1'b1 || hz.issue !== 1'b0) begin failures++; $display("FAIL lwi_busy1 busy=%0b stall=%0b issue=%0b exp 1/1/0", hz.lwi_busy, hz.stall_if, hz.issue); end
        tick();
        idle();
        sample();
        checks++; if (hz.lwi_busy !== 1'b1 || hz.stall_if !== 1'b1) begin failures++; $display("FAIL lwi_busy2 busy=%0b stall=%0b exp 1/1", hz.lwi_busy, hz.stall_if); end
        tick();
        sample();
        checks++; if (hz.lwi_busy !== 1'b0 || hz.stall_if !== 1'b0) begin failures++; $display("FAIL lwi_done busy=%0b stall=%0b exp 0/0", hz.lwi_busy, hz.stall_if); end
        drain();
        // Flow change while busy aborts the hold.
        idle(); hz.id_valid = 1'b1; hz.lwi = 1'b1;
        tick();
        idle(); hz.flow_change = 1'b1;
        sample();
        checks++; if (hz.lwi_busy !== 1'b1 || hz.stall_if !== 1'b0) begin failures++; $display("FAIL lwi_abort_cyc busy=%0b stall=%0b exp 1/0", hz.lwi_busy, hz.stall_if); end
        tick();
        idle();
        sample();
        checks++; if (hz.lwi_busy !== 1'b0) begin failures++; $display("FAIL lwi_abort busy=%0b exp 0", hz.lwi_busy); end
        drain();
        // Reset while busy.
        idle(); hz.id_valid = 1'b1; hz.lwi = 1'b1;
        tick();
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        checks++; if (hz.lwi_busy !== 1'b0 || hz.stall_if !== 1'b0) begin failures++; $display("FAIL lwi_rst busy=%0b stall=%0b exp 0/0", hz.lwi_busy, hz.stall_if); end
        tick(); drain();
    endtask

    task automatic test_halt();
        idle(); hz.id_valid = 1'b1; hz.hlt = 1'b1; hz.flow_change = 1'b1;
        tick();
        idle(); hz.id_valid = 1'b1;
        tick();
        sample();
        checks++; if (hz.issue !== 1'b1 || hz.stall_if !== 1'b0) begin failures++; $display("FAIL hlt_in_flush issue=%0b stall=%0b exp 1/0", hz.issue, hz.stall_if); end
        tick(); drain();
        idle(); hz.id_valid = 1'b1; hz.hlt = 1'b1;
        sample();
        checks++; if (hz.issue !== 1'b1) begin failures++; $display("FAIL hlt_issue got=%0b exp=1", hz.issue); end
        tick();
        idle(); hz.id_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            sample();
            checks++; if (hz.stall_if !== 1'b1 || hz.issue !== 1'b0) begin failures++; $display("FAIL hlt_hold t+%0d stall=%0b issue=%0b exp 1/0", c, hz.stall_if, hz.issue); end
            checks++; if (hz.hlt_wb !== (c >= 3)) begin failures++; $display("FAIL hlt_wb t+%0d got=%0b exp=%0b", c, hz.hlt_wb, (c >= 3)); end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        checks++; if (hz.stall_if !== 1'b0 || hz.hlt_wb !== 1'b0 || hz.issue !== 1'b1) begin failures++; $display("FAIL hlt_rst stall=%0b hlt_wb=%0b issue=%0b exp 0/0/1", hz.stall_if, hz.hlt_wb, hz.issue); end
        tick(); drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 63) == 0);
            hz.id_valid    = ($urandom_range(0, 9) < 8);
            hz.rf_re0      = $urandom_range(0, 1);
            hz.rf_re1      = $urandom_range(0, 1);
            hz.rf_p0_addr  = 4'($urandom_range(0, 3));
            hz.rf_p1_addr  = 4'($urandom_range(0, 3));
            hz.rf_we       = $urandom_range(0, 1);
            hz.rf_dst_addr = 4'($urandom_range(0, 3));
            hz.dm_re       = ($urandom_range(0, 9) < 3);
            hz.hlt         = ($urandom_range(0, 99) == 0);
            hz.lwi         = ($urandom_range(0, 9) == 0);
            hz.flow_change = ($urandom_range(0, 99) < 8);
            sample();
            checks++; if (hz.issue !== e_issue) begin failures++; $display("FAIL rnd_issue cyc=%0d got=%0b exp=%0b", i, hz.issue, e_issue); end
            checks++; if (hz.flush !== e_flush) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%0b exp=%0b", i, hz.flush, e_flush); end
            checks++; if (hz.stall_if !== e_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, hz.stall_if, e_stall); end
            checks++; if (hz.byp0 !== e_byp0) begin failures++; $display("FAIL rnd_byp0 cyc=%0d got=%b exp=%b", i, hz.byp0, e_byp0); end
            checks++; if (hz.byp1 !== e_byp1) begin failures++; $display("FAIL rnd_byp1 cyc=%0d got=%b exp=%b", i, hz.byp1, e_byp1); end
            checks++; if (hz.hlt_wb !== e_hlt_wb) begin failures++; $display("FAIL rnd_hlt_wb cyc=%0d got=%0b exp=%0b", i, hz.hlt_wb, e_hlt_wb); end
            checks++; if (hz.lwi_busy !== e_busy) begin failures++; $display("FAIL rnd_lwi_busy cyc=%0d got=%0b exp=%0b", i, hz.lwi_busy, e_busy); end
            tick();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_load_use();
        test_flush();
        test_lwi();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
